// File: rtl/r_type_mc_ctrl_if.sv
// Handshake/bus bundle between the R-type sequencer and its surrounding datapath.
// master = controller side, slave = datapath / instruction-memory side.
interface r_type_mc_ctrl_if #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             stall;
  logic [31:0]      inst;
  logic [PC_W-1:0]  pc;
  logic [31:0]      ir;
  logic [2:0]       alu_ctrl;
  logic             rf_we;
  logic [4:0]       wr_addr;
  logic             busy;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  start, stall, inst,
    output pc, ir, alu_ctrl, rf_we, wr_addr, busy, halted, illegal, retired
  );

  modport slave (
    output start, stall, inst,
    input  pc, ir, alu_ctrl, rf_we, wr_addr, busy, halted, illegal, retired
  );
endinterface

// File: rtl/r_type_mc_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for MIPS R-type instructions.
// Owns PC and IR; halts on an all-zero word or on an illegal instruction.
module r_type_mc_ctrl #(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned PC_INC = 4,
  parameter int unsigned CNT_W  = 16
) (
  input logic                clk,
  input logic                rst,
  r_type_mc_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWb,
    StHalt
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;

  function automatic logic funct_ok(input logic [5:0] f);
    case (f)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h2a: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_decode(input logic [5:0] f);
    case (f)
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // A stalled busy state holds everything; its action fires on the first unstalled cycle.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StFetch;
      end
      StFetch: begin
        if (!bus.stall) begin
          ir_d    = bus.inst;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (!bus.stall) begin
          if (ir_q == 32'd0) begin
            state_d = StHalt;
          end else if ((ir_q[31:26] != 6'd0) || !funct_ok(ir_q[5:0])) begin
            state_d   = StHalt;
            illegal_d = 1'b1;
          end else begin
            state_d = StExec;
          end
        end
      end
      StExec: begin
        if (!bus.stall) state_d = StWb;
      end
      StWb: begin
        if (!bus.stall) begin
          pc_d    = pc_q + PC_W'(PC_INC);
          state_d = StFetch;
          if (retired_q != {CNT_W{1'b1}}) retired_d = retired_q + CNT_W'(1);
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs depend only on registered state plus stall; inst reaches nothing combinationally.
  always_comb begin
    bus.alu_ctrl = 3'b010;
    if ((state_q == StExec) || (state_q == StWb)) bus.alu_ctrl = alu_decode(ir_q[5:0]);
  end

  assign bus.pc      = pc_q;
  assign bus.ir      = ir_q;
  assign bus.wr_addr = ir_q[15:11];
  assign bus.rf_we   = (state_q == StWb) && !bus.stall && (ir_q[15:11] != 5'd0);
  assign bus.busy    = (state_q == StFetch) || (state_q == StDecode) ||
                       (state_q == StExec)  || (state_q == StWb);
  assign bus.halted  = (state_q == StHalt);
  assign bus.illegal = illegal_q;
  assign bus.retired = retired_q;

endmodule
